// File: rtl/ex_stage.sv
// Execute stage: logic/shift/move ALU with HI/LO registers and a 32-cycle
// shift-add multiplier that stalls the pipeline while it runs.
module ex_stage (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  aluop_i,
   input  logic [2:0]  alusel_i,
   input  logic [31:0] reg1_i,
   input  logic [31:0] reg2_i,
   input  logic [4:0]  wd_i,
   input  logic        wreg_i,
   output logic [31:0] fwd_wdata_o,
   output logic [4:0]  fwd_wd_o,
   output logic        fwd_wreg_o,
   output logic [31:0] wdata_o,
   output logic [4:0]  wd_o,
   output logic        wreg_o,
   output logic [31:0] hi_o,
   output logic [31:0] lo_o,
   output logic        stallreq_o
);

   localparam logic [7:0] OP_AND   = 8'h24;
   localparam logic [7:0] OP_OR    = 8'h25;
   localparam logic [7:0] OP_XOR   = 8'h26;
   localparam logic [7:0] OP_NOR   = 8'h27;
   localparam logic [7:0] OP_SLL   = 8'h7C;
   localparam logic [7:0] OP_SRL   = 8'h02;
   localparam logic [7:0] OP_SRA   = 8'h03;
   localparam logic [7:0] OP_MFHI  = 8'h10;
   localparam logic [7:0] OP_MTHI  = 8'h11;
   localparam logic [7:0] OP_MFLO  = 8'h12;
   localparam logic [7:0] OP_MTLO  = 8'h13;
   localparam logic [7:0] OP_MULT  = 8'h18;
   localparam logic [7:0] OP_MULTU = 8'h19;

   localparam logic [2:0] SEL_LOGIC = 3'b001;
   localparam logic [2:0] SEL_SHIFT = 3'b010;
   localparam logic [2:0] SEL_MOVE  = 3'b011;

   typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

   state_t      state_q, state_d;
   logic [31:0] cnt_q, cnt_d;
   logic [63:0] acc_q, acc_d;
   logic [63:0] mcand_q, mcand_d;
   logic [31:0] mplier_q, mplier_d;
   logic        neg_q, neg_d;
   logic        blk_q, blk_d;
   logic [31:0] hi_q, lo_q;
   logic [31:0] wdata_q, wdata_d;
   logic [4:0]  wd_q, wd_d;
   logic        wreg_q, wreg_d;

   logic        is_mul, is_mt, stall, prod_wr;
   logic        a_neg, b_neg;
   logic [31:0] a_mag, b_mag;
   logic [63:0] product;
   logic [31:0] result;
   logic [31:0] sra_res;

   assign is_mul = (aluop_i == OP_MULT) || (aluop_i == OP_MULTU);
   assign is_mt  = (aluop_i == OP_MTHI) || (aluop_i == OP_MTLO);

   // Only signed MULT folds operands to magnitudes; the sign is restored on the product.
   assign a_neg = (aluop_i == OP_MULT) && reg1_i[31];
   assign b_neg = (aluop_i == OP_MULT) && reg2_i[31];
   assign a_mag = a_neg ? (~reg1_i + 32'd1) : reg1_i;
   assign b_mag = b_neg ? (~reg2_i + 32'd1) : reg2_i;
   assign product = neg_q ? (~acc_q + 64'd1) : acc_q;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      acc_d    = acc_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      neg_d    = neg_q;
      stall    = 1'b0;
      prod_wr  = 1'b0;
      case (state_q)
         S_IDLE: begin
            // blk_q keeps the still-present MULT from re-arming right after DONE
            if (is_mul && !blk_q) begin
               stall    = 1'b1;
               state_d  = S_BUSY;
               cnt_d    = 32'd0;
               acc_d    = 64'd0;
               mcand_d  = {32'd0, a_mag};
               mplier_d = b_mag;
               neg_d    = a_neg ^ b_neg;
            end
         end
         S_BUSY: begin
            stall = 1'b1;
            if (mplier_q[0]) acc_d = acc_q + mcand_q;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + 32'd1;
            if (cnt_q == 32'd31) state_d = S_DONE;
         end
         S_DONE: begin
            stall   = 1'b1;
            prod_wr = 1'b1;
            cnt_d   = 32'd0;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign blk_d   = (state_q == S_DONE);
   assign sra_res = 32'($signed(reg2_i) >>> reg1_i[4:0]);

   always_comb begin
      result = 32'd0;
      case (alusel_i)
         SEL_LOGIC: begin
            case (aluop_i)
               OP_OR:   result = reg1_i | reg2_i;
               OP_AND:  result = reg1_i & reg2_i;
               OP_XOR:  result = reg1_i ^ reg2_i;
               OP_NOR:  result = ~(reg1_i | reg2_i);
               default: result = 32'd0;
            endcase
         end
         SEL_SHIFT: begin
            case (aluop_i)
               OP_SLL:  result = reg2_i << reg1_i[4:0];
               OP_SRL:  result = reg2_i >> reg1_i[4:0];
               OP_SRA:  result = sra_res;
               default: result = 32'd0;
            endcase
         end
         SEL_MOVE: begin
            case (aluop_i)
               OP_MFHI: result = hi_q;
               OP_MFLO: result = lo_q;
               default: result = 32'd0;
            endcase
         end
         default: result = 32'd0;
      endcase
   end

   always_comb begin
      fwd_wdata_o = rst ? 32'd0 : result;
      fwd_wd_o    = rst ? 5'd0 : wd_i;
      fwd_wreg_o  = (rst || stall || is_mul || is_mt) ? 1'b0 : wreg_i;
      wdata_d     = fwd_wdata_o;
      wd_d        = fwd_wd_o;
      wreg_d      = fwd_wreg_o;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         cnt_q    <= 32'd0;
         acc_q    <= 64'd0;
         mcand_q  <= 64'd0;
         mplier_q <= 32'd0;
         neg_q    <= 1'b0;
         blk_q    <= 1'b0;
         hi_q     <= 32'd0;
         lo_q     <= 32'd0;
         wdata_q  <= 32'd0;
         wd_q     <= 5'd0;
         wreg_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         acc_q    <= acc_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         neg_q    <= neg_d;
         blk_q    <= blk_d;
         wdata_q  <= wdata_d;
         wd_q     <= wd_d;
         wreg_q   <= wreg_d;
         if (prod_wr) begin
            hi_q <= product[63:32];
            lo_q <= product[31:0];
         end else if (aluop_i == OP_MTHI) begin
            hi_q <= reg1_i;
         end else if (aluop_i == OP_MTLO) begin
            lo_q <= reg1_i;
         end
      end
   end

   assign wdata_o    = wdata_q;
   assign wd_o       = wd_q;
   assign wreg_o     = wreg_q;
   assign hi_o       = hi_q;
   assign lo_o       = lo_q;
   assign stallreq_o = stall && !rst;

endmodule
